// File: rtl/hdlc_host_pkg.sv
// hdlc_host_pkg: sequencer states and Hdlc register map constants
package hdlc_host_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RX_STAT, S_RX_DROP, S_RX_LEN, S_RX_DATA, S_TX_FILL, S_TX_START
  } state_e;
  localparam logic [2:0] TX_SC = 3'd0;
  localparam logic [2:0] TX_BUFF = 3'd1;
  localparam logic [2:0] RX_SC = 3'd2;
  localparam logic [2:0] RX_BUFF = 3'd3;
  localparam logic [2:0] RX_LEN = 3'd4;
  localparam logic [7:0] TX_ENABLE = 8'h02;
  localparam logic [7:0] RX_DROP = 8'h02;
  localparam logic [7:0] RX_ERR_MASK = 8'h1C;
endpackage

// File: rtl/hdlc_rx_outreg.sv
// hdlc_rx_outreg: single-entry valid/ready holding register for the received byte stream
module hdlc_rx_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic         free
);
  logic valid_q, valid_d, last_q, last_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    free = ~valid_q | ready;
    valid_d = load ? 1'b1 : valid_q & ~ready;
    last_d = load ? load_last : last_q & ~ready;
    data_d = load ? load_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end
  assign valid = valid_q;
  assign data = data_q;
  assign last = last_q;
endmodule

// File: rtl/hdlc_host_seq.sv
// hdlc_host_seq: sole master of the Hdlc register port; fills the Tx buffer from one
// byte stream and drains received frames into another, RX winning ties in IDLE.
module hdlc_host_seq
  import hdlc_host_pkg::*;
#(
  parameter int MAX_TX_LEN = 126,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              TxS_Valid,
  input  logic [DATA_W-1:0] TxS_Data,
  input  logic              TxS_Last,
  output logic              TxS_Ready,
  output logic              RxS_Valid,
  output logic [DATA_W-1:0] RxS_Data,
  output logic              RxS_Last,
  input  logic              RxS_Ready,
  output logic [ADDR_W-1:0] Address,
  output logic              WriteEnable,
  output logic              ReadEnable,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              Tx_Done,
  input  logic              Rx_Ready,
  output logic              TxOversize,
  output logic [7:0]        DropCount
);
  localparam int TW = $clog2(MAX_TX_LEN + 1);
  state_e state_q, state_d;
  logic phase_q, phase_d, oversize_q, oversize_d, ld, free;
  logic [TW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, len_q, len_d, drop_cnt_q, drop_cnt_d;
  hdlc_rx_outreg #(.W(DATA_W)) u_outreg (
    .clk(Clk), .rst(Rst), .load(ld), .load_data(DataOut), .load_last(rx_cnt_q == len_q),
    .ready(RxS_Ready), .valid(RxS_Valid), .data(RxS_Data), .last(RxS_Last), .free(free)
  );
  // phase_q: read issued last cycle (RX_STAT/LEN/DATA) or drop write done (RX_DROP)
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    oversize_d = oversize_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    len_d = len_q;
    drop_cnt_d = drop_cnt_q;
    Address = TX_SC;
    WriteEnable = 1'b0;
    ReadEnable = 1'b0;
    DataIn = '0;
    TxS_Ready = 1'b0;
    ld = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        rx_cnt_d = '0;
        state_d = Rx_Ready ? S_RX_STAT : (TxS_Valid && Tx_Done) ? S_TX_FILL : S_IDLE;
      end
      S_RX_STAT: begin
        Address = RX_SC;
        ReadEnable = ~phase_q;
        phase_d = ~phase_q;
        if (phase_q) state_d = |(DataOut & RX_ERR_MASK) ? S_RX_DROP : S_RX_LEN;
      end
      S_RX_LEN: begin
        Address = RX_LEN;
        ReadEnable = ~phase_q;
        phase_d = ~phase_q;
        if (phase_q) begin
          len_d = DataOut;
          state_d = DataOut == '0 ? S_RX_DROP : S_RX_DATA;
        end
      end
      S_RX_DROP: begin
        Address = RX_SC;
        WriteEnable = ~phase_q;
        DataIn = phase_q ? '0 : RX_DROP;
        phase_d = 1'b1;
        if (!phase_q) drop_cnt_d = drop_cnt_q == 8'hFF ? drop_cnt_q : drop_cnt_q + 8'd1;
        if (phase_q && !Rx_Ready) state_d = S_IDLE;
      end
      S_RX_DATA: begin
        Address = RX_BUFF;
        ReadEnable = ~phase_q & (rx_cnt_q < len_q) & free;
        phase_d = ReadEnable;
        ld = phase_q;
        rx_cnt_d = rx_cnt_q + {7'd0, ReadEnable};
        if (RxS_Valid && RxS_Ready && RxS_Last) state_d = S_IDLE;
      end
      S_TX_FILL: begin
        TxS_Ready = TxS_Valid;
        if (TxS_Valid) begin
          if (tx_cnt_q < TW'(MAX_TX_LEN)) begin
            Address = TX_BUFF;
            WriteEnable = 1'b1;
            DataIn = TxS_Data;
            tx_cnt_d = tx_cnt_q + TW'(1);
          end else begin
            oversize_d = 1'b1;
          end
          if (TxS_Last) state_d = S_TX_START;
        end
      end
      S_TX_START: begin
        Address = TX_SC;
        WriteEnable = 1'b1;
        DataIn = TX_ENABLE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) phase_d = 1'b0;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      oversize_q <= 1'b0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      len_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      oversize_q <= oversize_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      len_q <= len_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign TxOversize = oversize_q;
  assign DropCount = drop_cnt_q;
endmodule

// File: tb/tb_hdlc_host_seq.sv
// tb_hdlc_host_seq: scoreboard bench with a behavioural Hdlc register-port model
module tb_hdlc_host_seq;
  logic Clk = 1'b0, Rst = 1'b1;
  logic TxS_Valid = 1'b0, TxS_Last = 1'b0, TxS_Ready;
  logic RxS_Valid, RxS_Last, RxS_Ready = 1'b1;
  logic [7:0] TxS_Data = 8'h00, RxS_Data, DataIn, DropCount;
  logic [7:0] DataOut = 8'h00;
  logic [2:0] Address;
  logic WriteEnable, ReadEnable, TxOversize;
  logic Tx_Done = 1'b1, Rx_Ready = 1'b0;
  int n_cmp = 0, n_err = 0;
  int rd3_cnt = 0, wr2_cnt = 0, acc_cnt = 0, rd3_base = 0, wr2_base = 0;
  logic [7:0] m_sc = 8'h00, m_len = 8'h00;
  logic [7:0] buf_q[$];
  logic [11:0] exp_bus[$];
  logic [8:0] exp_rx[$];

  hdlc_host_seq dut (
    .Clk(Clk), .Rst(Rst), .TxS_Valid(TxS_Valid), .TxS_Data(TxS_Data), .TxS_Last(TxS_Last),
    .TxS_Ready(TxS_Ready), .RxS_Valid(RxS_Valid), .RxS_Data(RxS_Data), .RxS_Last(RxS_Last),
    .RxS_Ready(RxS_Ready), .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .DataIn(DataIn), .DataOut(DataOut), .Tx_Done(Tx_Done), .Rx_Ready(Rx_Ready),
    .TxOversize(TxOversize), .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ba(input logic we, input logic [2:0] a, input logic [7:0] d);
    return {we, a, we ? d : 8'h00};
  endfunction

  always @(posedge Clk)
    if (ReadEnable && !Rst) begin
      if (Address == 3'd2) DataOut <= m_sc;
      else if (Address == 3'd4) DataOut <= m_len;
      else if (Address == 3'd3 && buf_q.size() != 0) DataOut <= buf_q.pop_front();
      else DataOut <= 8'hEE;
    end

  always @(negedge Clk)
    if (!Rst) begin
      if (WriteEnable || ReadEnable) begin
        chk("we_re_excl", 32'(WriteEnable & ReadEnable), 32'd0);
        if (exp_bus.size() == 0) chk("bus_unexp", 32'(ba(WriteEnable, Address, DataIn)), 32'hFFFF_FFFF);
        else chk("bus", 32'(ba(WriteEnable, Address, DataIn)), 32'(exp_bus.pop_front()));
        if (ReadEnable && Address == 3'd3) rd3_cnt++;
        if (WriteEnable && Address == 3'd2) wr2_cnt++;
      end
      if (RxS_Valid && RxS_Ready) begin
        acc_cnt++;
        if (exp_rx.size() == 0) chk("rx_unexp", 32'({RxS_Last, RxS_Data}), 32'hFFFF_FFFF);
        else chk("rx_byte", 32'({RxS_Last, RxS_Data}), 32'(exp_rx.pop_front()));
      end
    end

  task automatic nxt;
    @(posedge Clk);
    #1;
  endtask

  task automatic smp;
    @(negedge Clk);
    #1;
  endtask

  function automatic logic [7:0] tx_byte(input int i);
    return 8'(8'hA1 + i * 17);
  endfunction

  task automatic push_tx(input int n);
    for (int i = 0; i < n; i++)
      if (i < 126) exp_bus.push_back(ba(1'b1, 3'd1, tx_byte(i)));
    exp_bus.push_back(ba(1'b1, 3'd0, 8'h02));
  endtask

  task automatic drive_tx(input int n, input int rx_at);
    int t;
    for (int i = 0; i < n; i++) begin
      TxS_Valid = 1'b1;
      TxS_Data = tx_byte(i);
      TxS_Last = (i == n - 1);
      if (i == rx_at) Rx_Ready = 1'b1;
      t = 0;
      smp;
      while (!TxS_Ready && t < 50) begin
        smp;
        t++;
      end
      if (i == 0) chk("tx_start", 32'(TxS_Ready), 32'd1);
      else chk("tx_stall", t, 0);
      nxt;
    end
    TxS_Valid = 1'b0;
    TxS_Last = 1'b0;
  endtask

  function automatic bit is_drop(input logic [7:0] sc, input int len);
    return (sc & 8'h1C) != 8'h00 || len == 0;
  endfunction

  task automatic rx_setup(input logic [7:0] sc, input int len);
    logic [7:0] b;
    m_sc = sc;
    m_len = 8'(len);
    rd3_base = rd3_cnt;
    wr2_base = wr2_cnt;
    exp_bus.push_back(ba(1'b0, 3'd2, 8'h00));
    if ((sc & 8'h1C) == 8'h00) exp_bus.push_back(ba(1'b0, 3'd4, 8'h00));
    if (is_drop(sc, len)) exp_bus.push_back(ba(1'b1, 3'd2, 8'h02));
    else
      for (int i = 0; i < len; i++) begin
        b = 8'(17 * (i + 1));
        buf_q.push_back(b);
        exp_bus.push_back(ba(1'b0, 3'd3, 8'h00));
        exp_rx.push_back({i == len - 1, b});
      end
  endtask

  task automatic rx_run(input logic [7:0] sc, input int len);
    int t = 0;
    if (is_drop(sc, len)) begin
      while (wr2_cnt == wr2_base && t < 400) begin
        smp;
        t++;
      end
      chk("drop_wr", wr2_cnt - wr2_base, 1);
    end else begin
      while (rd3_cnt - rd3_base < len && t < 400) begin
        smp;
        t++;
      end
      chk("rd3_cnt", rd3_cnt - rd3_base, len);
    end
    nxt;
    Rx_Ready = 1'b0;
    t = 0;
    while (exp_rx.size() != 0 && t < 100) begin
      smp;
      t++;
    end
    chk("rx_drain", exp_rx.size(), 0);
    repeat (3) nxt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int t, base;
    repeat (3) nxt;
    smp;
    chk("rst_bus", 32'({Address, WriteEnable, ReadEnable, DataIn}), 32'd0);
    chk("rst_strm", 32'({TxS_Ready, RxS_Valid, RxS_Last, RxS_Data}), 32'd0);
    chk("rst_stat", 32'({TxOversize, DropCount}), 32'd0);
    nxt;
    Rst = 1'b0;
    nxt;
    Tx_Done = 1'b0;
    TxS_Valid = 1'b1;
    TxS_Data = 8'h5A;
    TxS_Last = 1'b1;
    repeat (4) begin
      smp;
      chk("txdone_gate", 32'({TxS_Ready, WriteEnable}), 32'd0);
    end
    nxt;
    TxS_Valid = 1'b0;
    TxS_Last = 1'b0;
    Tx_Done = 1'b1;
    nxt;
    push_tx(3);
    drive_tx(3, -1);
    repeat (3) nxt;
    chk("tx3_bus_done", exp_bus.size(), 0);
    chk("tx3_ovs", 32'(TxOversize), 32'd0);
    rx_setup(8'h01, 4);
    Rx_Ready = 1'b1;
    rx_run(8'h01, 4);
    rx_setup(8'h01, 4);
    RxS_Ready = 1'b0;
    Rx_Ready = 1'b1;
    t = 0;
    smp;
    while (!RxS_Valid && t < 50) begin
      smp;
      t++;
    end
    chk("bp_first", 32'(RxS_Valid), 32'd1);
    repeat (5) begin
      chk("bp_hold", 32'({RxS_Valid, RxS_Data}), 32'h111);
      chk("bp_noread", 32'(ReadEnable), 32'd0);
      smp;
    end
    nxt;
    RxS_Ready = 1'b1;
    rx_run(8'h01, 4);
    rx_setup(8'h05, 4);
    Rx_Ready = 1'b1;
    rx_run(8'h05, 4);
    chk("drop_first", 32'(DropCount), 32'd1);
    rx_setup(8'h01, 0);
    Rx_Ready = 1'b1;
    rx_run(8'h01, 0);
    chk("drop_len0", 32'(DropCount), 32'd2);
    for (int k = 0; k < 300; k++) begin
      rx_setup(8'(8'h04 << (k % 3)) | 8'h01, 4);
      Rx_Ready = 1'b1;
      rx_run(8'(8'h04 << (k % 3)) | 8'h01, 4);
    end
    chk("drop_sat", 32'(DropCount), 32'd255);
    push_tx(126);
    drive_tx(126, -1);
    repeat (3) nxt;
    chk("tx126_ovs", 32'(TxOversize), 32'd0);
    push_tx(130);
    rx_setup(8'h01, 1);
    drive_tx(130, 10);
    rx_run(8'h01, 1);
    chk("tx130_ovs", 32'(TxOversize), 32'd1);
    chk("tx130_bus_done", exp_bus.size(), 0);
    rx_setup(8'h01, 4);
    Rx_Ready = 1'b1;
    base = acc_cnt;
    t = 0;
    smp;
    while (acc_cnt - base < 2 && t < 100) begin
      smp;
      t++;
    end
    chk("rst_mid_acc", acc_cnt - base, 2);
    nxt;
    Rst = 1'b1;
    Rx_Ready = 1'b0;
    exp_bus.delete();
    exp_rx.delete();
    buf_q.delete();
    nxt;
    smp;
    chk("mid_rst_bus", 32'({Address, WriteEnable, ReadEnable, DataIn}), 32'd0);
    chk("mid_rst_strm", 32'({TxS_Ready, RxS_Valid, RxS_Last, RxS_Data}), 32'd0);
    chk("mid_rst_stat", 32'({TxOversize, DropCount}), 32'd0);
    nxt;
    Rst = 1'b0;
    repeat (10) nxt;
    chk("bus_left", exp_bus.size(), 0);
    chk("rx_left", exp_rx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hdlc_host_seq.md
Name: hdlc_host_seq

Overview:
- Register-bus master that sequences the Hdlc core on behalf of two byte streams.
- Moves an outgoing byte stream into the Tx buffer, then starts transmission.
- When Rx_Ready is raised, drains the received frame from the Rx buffer into an outgoing byte stream.
- Sits between system logic and the Hdlc register port. It is the only master on that port and arbitrates TX fill against RX drain.

Parameters:
- MAX_TX_LEN, 126, maximum bytes written to the Tx buffer per frame.
- DATA_W, 8, register data width (fixed at 8).
- ADDR_W, 3, register address width.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-high.
- TxS_Valid  in  1  transmit byte valid.
- TxS_Data  in  8  transmit byte.
- TxS_Last  in  1  marks the final byte of a frame.
- TxS_Ready  out  1  transmit byte accepted this cycle.
- RxS_Valid  out  1  received byte valid.
- RxS_Data  out  8  received byte.
- RxS_Last  out  1  marks the final byte of a frame.
- RxS_Ready  in  1  downstream accepts the byte.
- Address  out  3  Hdlc register address.
- WriteEnable  out  1  Hdlc register write strobe.
- ReadEnable  out  1  Hdlc register read strobe.
- DataIn  out  8  write data to Hdlc.
- DataOut  in  8  read data from Hdlc; valid the cycle after ReadEnable.
- Tx_Done  in  1  Hdlc Tx buffer empty / idle.
- Rx_Ready  in  1  Hdlc holds a complete received frame.
- TxOversize  out  1  sticky; set when a frame exceeded MAX_TX_LEN; cleared by Rst.
- DropCount  out  8  saturating count of erroneous Rx frames dropped.

Behaviour:
- Hdlc register map:
  - 0 Tx_SC: bit1 Tx_Enable.
  - 1 Tx_Buff.
  - 2 Rx_SC: bit0 Rx_Ready, bit1 Rx_Drop, bit2 FrameError, bit3 AbortSignal, bit4 Overflow.
  - 3 Rx_Buff.
  - 4 Rx_Len.
- Bus rules:
  - At most one access per cycle; WriteEnable and ReadEnable are never both high.
  - A write completes in one cycle.
  - A read issued in cycle N is sampled from DataOut in N+1; no new read is issued in N+1.
- Reset: state IDLE; Address=0; DataIn=0; WriteEnable=0; ReadEnable=0; TxS_Ready=0; RxS_Valid=0; RxS_Last=0; RxS_Data=0; TxOversize=0; DropCount=0; byte counters 0. Rst mid-frame abandons the frame immediately and issues no further bus access.
- Arbitration in IDLE: Rx_Ready has priority over a TX start. Once entered, a TX fill runs to completion; RX is serviced afterwards.
- FSM states:
  - IDLE:
    - Rx_Ready=1 -> RX_STAT.
    - Else TxS_Valid=1 and Tx_Done=1 -> TX_FILL.
  - RX_STAT:
    - Read addr 2, then evaluate bits 4:2.
    - Any bit set -> RX_DROP.
    - Otherwise -> RX_LEN.
  - RX_DROP:
    - Write 0x02 to addr 2 (one cycle).
    - DropCount+1, saturating at 255.
    - Wait in RX_DROP until Rx_Ready=0, then -> IDLE.
  - RX_LEN:
    - Read addr 4 and latch len.
    - len=0 -> RX_DROP, counted.
    - Otherwise -> RX_DATA.
  - RX_DATA:
    - Single-entry output register. A read of addr 3 is issued only when the register is empty, or is being accepted this cycle (RxS_Valid & RxS_Ready).
    - Read data loads RxS_Data with RxS_Valid=1; RxS_Last=1 on byte len.
    - RxS_Valid holds, with data stable, until RxS_Ready.
    - After the last byte is accepted -> IDLE.
    - Back-to-back accepts sustain one byte every 2 cycles.
  - TX_FILL:
    - TxS_Ready=1 in every cycle with TxS_Valid=1.
    - Each accepted byte with count < MAX_TX_LEN is written to addr 1 in the same cycle; count+1.
    - Bytes beyond MAX_TX_LEN are accepted, not written, and set TxOversize.
    - Accepting a byte with TxS_Last=1 -> TX_START.
  - TX_START: write 0x02 to addr 0 (one cycle), then -> IDLE.
- Tx_Done is only checked at frame start. The next frame waits in IDLE until Tx_Done=1 again.
- Boundaries:
  - A frame of exactly MAX_TX_LEN bytes does not set TxOversize.
  - Rx_Ready rising during TX_FILL is held off until TX_START completes.
  - A one-byte frame (TxS_Last on first byte) is legal.

Decomposition:
- Shared package hdlc_host_pkg:
  - state enum.
  - register address constants (TX_SC=0, TX_BUFF=1, RX_SC=2, RX_BUFF=3, RX_LEN=4).
  - bit constants (TX_ENABLE=0x02, RX_DROP=0x02, RX_ERR_MASK=0x1C).
- One sub-module is natural: hdlc_rx_outreg, the single-entry valid/ready output register for the RX stream.

Test Plan:
- TX frame: 3 bytes 0xA1,0xB2,0xC3 with Last on 0xC3, Tx_Done=1 -> writes addr1 0xA1/0xB2/0xC3 on consecutive cycles, then addr0 0x02; TxOversize=0.
- RX frame: Rx_Ready=1, Rx_SC=0x01, Rx_Len=4, Rx_Buff yields 0x11..0x44, RxS_Ready=1 -> reads addr2, addr4, 4×addr3; 4 bytes out with RxS_Last on 0x44.
- RX backpressure: same frame, RxS_Ready=0 for 5 cycles after the first byte -> RxS_Data=0x11 held; no addr3 read issued until accept; byte order intact.
- RX error: Rx_SC=0x05 -> write 0x02 to addr2; no RxS_Valid; DropCount 0->1. Repeat 300 times -> DropCount saturates at 255.
- Oversize/priority: 130-byte TX frame, Rx_Ready rises at byte 10 -> exactly 126 addr1 writes, TxOversize=1, addr0 0x02 written, then RX_STAT read.
- Reset mid-RX_DATA after 2 of 4 bytes -> next cycle all outputs 0, state IDLE, no further bus access.
